fixed_point_alu: RTL and testbench
==================================

// Module: fixed_point_alu
// PURPOSE
//  Sequential sign-magnitude fixed-point arithmetic unit. Default format: bit31 = sign,
//  [30:16] = integer, [15:0] = fraction.
//  Provides add, subtract, multiply, divide and absolute value for the constraint-enforcement
//  datapath (point position/distance math). One operation is in flight at a time.
// PARAMETERS
//  W     32  total word width (sign + magnitude)
//  FRAC  16  fraction bits; 1.0 == 1<<FRAC
// PORTS
//  clk     in   1  rising-edge clock (single clock domain)
//  rst_n   in   1  reset, asynchronous assert, active-low
//  start   in   1  launch op; accepted only when busy==0
//  op      in   3  000 add, 001 sub, 010 mul, 011 div, 100 abs(a); others -> result 0
//  a       in   W  operand A, sign-magnitude
//  b       in   W  operand B, sign-magnitude (ignored for abs)
//  result  out  W  last completed result, held until next valid
//  valid   out  1  one-cycle pulse when result/ovf/dz update
//  busy    out  1  high while a divide is iterating
//  ovf     out  1  magnitude overflow on last op
//  dz      out  1  divide by zero on last op
// BEHAVIOUR
//  - Reset (rst_n=0, async): result=0, valid=0, busy=0, ovf=0, dz=0; any divide in progress is discarded.
//  - Operands are captured on the start cycle; later changes on a/b/op have no effect.
//  - add/sub/mul/abs: result and valid appear on the edge after the start edge (latency 1).
//  - div: busy=1 from the edge after start; restoring divider, one quotient bit per cycle,
//    W-1 iterations. valid pulses with busy falling, W cycles after start (32 at default W).
//  - start while busy=1 is ignored; no queueing.
//  - add: equal signs -> magnitudes add, sign kept. Differing signs -> larger minus smaller,
//    sign of the larger magnitude. Equal magnitudes -> +0.
//  - sub: identical to add with b's sign bit inverted.
//  - mul: mag = (|a|*|b|) >> FRAC, truncated toward zero; sign = sa^sb.
//  - div: mag = (|a| << FRAC) / |b|, truncated; sign = sa^sb.
//  - abs: result = {1'b0, a[W-2:0]}; ovf=0.
//  - Overflow: magnitude needs more than W-1 bits -> ovf=1.
//  - Divide by zero (|b|==0): dz=1, ovf=0; magnitude = all ones (saturated), sign = sa.
//    Takes the same full latency as a normal divide.
//  - Negative zero: any zero magnitude is output as 0x00000000 (sign cleared), including inputs
//    like 0x80000000.
//  - ovf and dz update only on valid and hold otherwise.
// CONFIGURATION
//  FXP_SATURATE_EN defined:
//    - overflowing add/sub/mul/div results clamp to magnitude 2^(W-1)-1 with the computed sign.
//    - ovf is still set.
//  FXP_SATURATE_EN undefined:
//    - magnitude wraps (low W-1 bits kept), sign as computed; ovf still set.
//  Divide-by-zero saturates in both builds.
// TESTING
//  - add 0x00018000 + 0x80008000 -> result 0x00010000, valid 1 cycle after start, ovf=0.
//  - sub 0x00010000 - 0x0000F000 -> 0x00001000.
//    Then sub 0x00010000 - 0x00010000 -> 0x00000000 (no negative zero).
//  - mul 0x00020000 * 0x80018000 -> 0x80030000.
//    Then mul 0x7FFF0000 * 0x00020000 -> ovf=1 and 0x7FFFFFFF with FXP_SATURATE_EN.
//  - div 0x00010000 / 0x00030000 -> 0x00005555 after 32 cycles, busy high throughout.
//    A second start mid-divide is ignored.
//  - div 0x80010000 / 0x00000000 -> dz=1, result 0xFFFFFFFF.
//    abs 0x80012345 -> 0x00012345.
//  - Assert rst_n=0 at divide cycle 10 -> busy, valid, result, flags all 0 immediately.
//    No valid pulse follows reset release.

Source files
------------

// File: rtl/fixed_point_alu.sv
// Sign-magnitude fixed-point ALU: single-cycle add/sub/mul/abs, multi-cycle restoring divide.
// Build option FXP_SATURATE_EN: clamp overflowing results instead of wrapping the magnitude.
module fixed_point_alu #(
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         valid,
  output logic         busy,
  output logic         ovf,
  output logic         dz
);
  localparam int M  = W - 1;
  localparam int PW = 2 * M;
  localparam int CW = $clog2(M);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_ABS = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIN} state_t;
  state_t state, state_nxt;

  // Handshake: start is taken only in S_IDLE; valid is a one-cycle pulse per accepted op.
  logic accept;
  assign accept = start && (state == S_IDLE);

  logic          sa, sb;
  logic [M-1:0]  ma, mb;
  logic [M:0]    sum;
  logic          add_sign;
  logic [PW-1:0] mul_shift;
  logic          fast_sign, fast_ovf;
  logic [M-1:0]  fast_mag;
  logic [FRAC-1:0] dh;
  logic [M-1:0]  rem_init;

  // divider state
  logic [M-1:0]  rem, dvd, quo, dbm;
  logic          dsign, dovf, ddz;
  logic [CW-1:0] cnt;
  logic [M:0]    trial, diff;

  function automatic logic [W-1:0] pack(input logic sign, input logic [M-1:0] mag,
                                        input logic over);
    logic [M-1:0] m;
    m = mag;
`ifdef FXP_SATURATE_EN
    if (over) m = '1;
`else
    if (over) m = mag;
`endif
    return (m == '0) ? '0 : {sign, m};
  endfunction

  always_comb begin
    sa        = a[M];
    sb        = (op == OP_SUB) ? ~b[M] : b[M];
    ma        = a[M-1:0];
    mb        = b[M-1:0];
    sum       = '0;
    add_sign  = sa;
    if (sa == sb) begin
      sum = {1'b0, ma} + {1'b0, mb};
    end else if (ma >= mb) begin
      sum = {1'b0, ma - mb};
    end else begin
      sum      = {1'b0, mb - ma};
      add_sign = sb;
    end
    mul_shift = (PW'(ma) * PW'(mb)) >> FRAC;
    fast_sign = 1'b0;
    fast_mag  = '0;
    fast_ovf  = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        fast_sign = add_sign;
        fast_mag  = sum[M-1:0];
        fast_ovf  = sum[M];
      end
      OP_MUL: begin
        fast_sign = sa ^ b[M];
        fast_mag  = mul_shift[M-1:0];
        fast_ovf  = |mul_shift[PW-1:M];
      end
      OP_ABS:  fast_mag = ma;
      default: fast_mag = '0;
    endcase
  end

  // Quotient bits above M are dh/b; seeding the remainder with dh mod b keeps the low M bits exact.
  always_comb begin
    dh = ma[M-1:M-FRAC];
`ifdef FXP_SATURATE_EN
    rem_init = M'(dh);
`else
    rem_init = (mb == '0) ? '0 : (M'(dh) % mb);
`endif
    trial = {rem, dvd[M-1]};
    diff  = trial - {1'b0, dbm};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && op == OP_DIV) state_nxt = S_DIV;
      S_DIV:   if (cnt == CW'(M - 1)) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem   <= '0;
      dvd   <= '0;
      quo   <= '0;
      dbm   <= '0;
      dsign <= 1'b0;
      dovf  <= 1'b0;
      ddz   <= 1'b0;
      cnt   <= '0;
    end else if (accept && op == OP_DIV) begin
      rem   <= rem_init;
      dvd   <= {ma[M-FRAC-1:0], {FRAC{1'b0}}};
      quo   <= '0;
      dbm   <= mb;
      dsign <= sa ^ b[M];
      dovf  <= (mb != '0) && (M'(dh) >= mb);
      ddz   <= (mb == '0);
      cnt   <= '0;
    end else if (state == S_DIV) begin
      rem <= diff[M] ? trial[M-1:0] : diff[M-1:0];
      quo <= {quo[M-2:0], ~diff[M]};
      dvd <= {dvd[M-2:0], 1'b0};
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      valid  <= 1'b0;
      ovf    <= 1'b0;
      dz     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (accept && op != OP_DIV) begin
        result <= pack(fast_sign, fast_mag, fast_ovf);
        ovf    <= fast_ovf;
        dz     <= 1'b0;
        valid  <= 1'b1;
      end else if (state == S_FIN) begin
        if (ddz) begin
          result <= {dsign, {M{1'b1}}};
          ovf    <= 1'b0;
          dz     <= 1'b1;
        end else begin
          result <= pack(dsign, quo, dovf);
          ovf    <= dovf;
          dz     <= 1'b0;
        end
        valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fixed_point_alu.sv
// Directed-vector bench for fixed_point_alu; expected values are hand-computed Q15.16 results.
module tb_fixed_point_alu;
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op    = 3'b000;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic [31:0] result;
  logic        valid, busy, ovf, dz;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  fixed_point_alu #(.W(32), .FRAC(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .result(result), .valid(valid), .busy(busy), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

`ifdef FXP_SATURATE_EN
  localparam logic [31:0] MUL_OVF_RES = 32'h7FFF_FFFF;
  localparam logic [31:0] ADD_OVF_RES = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] MUL_OVF_RES = 32'h7FFE_0000;
  localparam logic [31:0] ADD_OVF_RES = 32'h0000_0000;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic fast_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] e_res, input logic e_ovf);
    exp_q.push_back(e_res);
    launch(o, x, y);
    check({tag, "_valid"}, valid, 1);
    check({tag, "_res"}, result, exp_q.pop_front());
    check({tag, "_ovf"}, ovf, e_ovf);
    check({tag, "_dz"}, dz, 0);
    @(posedge clk); #1;
    check({tag, "_pulse"}, valid, 0);
  endtask

  task automatic div_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] e_res, input logic e_ovf, input logic e_dz,
                        input bit poke);
    int  cycles;
    bit  busy_drop;
    exp_q.push_back(e_res);
    launch(3'b011, x, y);
    check({tag, "_busy0"}, busy, 1);
    a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    cycles    = 0;
    busy_drop = 0;
    while (!valid && cycles < 100) begin
      if (poke && cycles == 5) begin
        op = 3'b000; a = 32'h0001_0000; b = 32'h0001_0000; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
      if (!valid && !busy) busy_drop = 1;
    end
    start = 1'b0;
    check({tag, "_valid"}, valid, 1);
    check({tag, "_lat"}, cycles, 32);
    check({tag, "_busyhi"}, busy_drop, 0);
    check({tag, "_busyend"}, busy, 0);
    check({tag, "_res"}, result, exp_q.pop_front());
    check({tag, "_ovf"}, ovf, e_ovf);
    check({tag, "_dz"}, dz, e_dz);
  endtask

  initial begin
    int vcount;
    repeat (3) @(posedge clk);
    #1;
    check("rst_res", result, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_dz", dz, 0);
    @(negedge clk);
    rst_n = 1'b1;

    fast_op("add_mix",   3'b000, 32'h0001_8000, 32'h8000_8000, 32'h0001_0000, 0);
    fast_op("add_negbig",3'b000, 32'h0001_0000, 32'h8003_0000, 32'h8002_0000, 0);
    fast_op("sub_pos",   3'b001, 32'h0001_0000, 32'h0000_F000, 32'h0000_1000, 0);
    fast_op("sub_zero",  3'b001, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 0);
    fast_op("add_nzero", 3'b000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 0);
    fast_op("add_ovf",   3'b000, 32'h7FFF_FFFF, 32'h0000_0001, ADD_OVF_RES, 1);
    fast_op("mul_neg",   3'b010, 32'h0002_0000, 32'h8001_8000, 32'h8003_0000, 0);
    fast_op("mul_nn",    3'b010, 32'h8002_0000, 32'h8000_8000, 32'h0001_0000, 0);
    fast_op("abs_neg",   3'b100, 32'h8001_2345, 32'h1234_5678, 32'h0001_2345, 0);
    fast_op("abs_nzero", 3'b100, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 0);
    fast_op("bad_op",    3'b111, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 0);

    div_op("div_third", 32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 0, 0, 1);
    div_op("div_neg",   32'h8003_0000, 32'h0002_0000, 32'h8001_8000, 0, 0, 0);
    div_op("div_zero",  32'h8001_0000, 32'h0000_0000, 32'hFFFF_FFFF, 0, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    check("dz_hold", dz, 1);
    fast_op("abs_clr",  3'b100, 32'h8001_2345, 32'h0000_0000, 32'h0001_2345, 0);
    fast_op("mul_ovf",  3'b010, 32'h7FFF_0000, 32'h0002_0000, MUL_OVF_RES, 1);

    launch(3'b011, 32'h0001_0000, 32'h0003_0000);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_res", result, 0);
    check("arst_valid", valid, 0);
    check("arst_busy", busy, 0);
    check("arst_ovf", ovf, 0);
    check("arst_dz", dz, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    vcount = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid) vcount++;
    end
    check("post_rst_valid", vcount, 0);
    check("post_rst_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
